// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-issue / result-capture stage:
// FSM encoding, ALU widths, flag bit positions and select codes.
package alu_pkg;

  localparam int ALU_W          = 8;
  localparam int ALU_FLAG_W     = 8;
  localparam int ALU_FLAG_CARRY = 0;

  localparam logic [1:0] ALU_SEL_ADD = 2'b00;
  localparam logic [1:0] ALU_SEL_SUB = 2'b01;
  localparam logic [1:0] ALU_SEL_AND = 2'b10;
  localparam logic [1:0] ALU_SEL_OR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Carry-in chosen at accept: stored carry-out for chained multi-byte ops.
  function automatic logic carry_pick(input logic chain, input logic stored, input logic cin);
    return chain ? stored : cin;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Command, ALU-side and result bundles for alu_seq.
// Optional ALU_SEQ_ACC_EN adds the cmd_acc accumulate request.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int FLAGW = ALU_FLAG_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       cmd_sel;
  logic             cmd_cin;
  logic             cmd_chain;
`ifdef ALU_SEQ_ACC_EN
  logic             cmd_acc;
`endif

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_c;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_o;
  logic [FLAGW-1:0] alu_flag;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_o;
  logic [FLAGW-1:0] res_flag;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_cin, cmd_chain,
`ifdef ALU_SEQ_ACC_EN
    input  cmd_acc,
`endif
    input  alu_o, alu_flag, res_ready,
    output cmd_ready, alu_a, alu_b, alu_c, alu_sel,
    output res_valid, res_o, res_flag
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_cin, cmd_chain,
`ifdef ALU_SEQ_ACC_EN
    output cmd_acc,
`endif
    output alu_o, alu_flag, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_c, alu_sel,
    input  res_valid, res_o, res_flag
  );

endinterface

// File: rtl/alu_seq.sv
// Operand-issue and result-capture stage around a combinational 8-bit ALU.
// Optional feature macro: ALU_SEQ_ACC_EN (cmd_acc feeds last result into alu_a).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int FLAGW = ALU_FLAG_W,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_seq_if.slave        bus,
  output logic [CNTW-1:0] op_count
);

  state_t           state_q, state_d;
  logic             cmd_ready_c;
  logic             res_valid_c;
  logic             accept;
  logic             deliver;

  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             alu_c_q;
  logic [1:0]       alu_sel_q;
  logic             carry_q;
  logic [WIDTH-1:0] res_o_q;
  logic [FLAGW-1:0] res_flag_q;
  logic [CNTW-1:0]  count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Ready is held low while reset is asserted so no handshake can complete.
  always_comb begin
    state_d     = state_q;
    cmd_ready_c = 1'b0;
    res_valid_c = 1'b0;
    unique case (state_q)
      ST_IDLE: cmd_ready_c = rst_n;
      ST_HOLD: begin
        res_valid_c = 1'b1;
        cmd_ready_c = rst_n & bus.res_ready;
      end
      default: ;
    endcase
    accept  = bus.cmd_valid & cmd_ready_c;
    deliver = res_valid_c & bus.res_ready;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (bus.res_ready) state_d = accept ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_SEQ_ACC_EN
  assign opa_d = bus.cmd_acc ? res_o_q : bus.cmd_a;
`else
  assign opa_d = bus.cmd_a;
`endif

  // Issue stage: operands held on the ALU inputs from accept to next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_c_q   <= 1'b0;
      alu_sel_q <= '0;
    end else if (accept) begin
      alu_a_q   <= opa_d;
      alu_b_q   <= bus.cmd_b;
      alu_c_q   <= carry_pick(bus.cmd_chain, carry_q, bus.cmd_cin);
      alu_sel_q <= bus.cmd_sel;
    end
  end

  // Capture stage: ALU has settled by the end of the single EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_o_q    <= '0;
      res_flag_q <= '0;
      carry_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      res_o_q    <= bus.alu_o;
      res_flag_q <= bus.alu_flag;
      carry_q    <= bus.alu_flag[ALU_FLAG_CARRY];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count_q <= '0;
    else if (deliver) count_q <= count_q + 1'b1;
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_c     = alu_c_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_valid = res_valid_c;
  assign bus.res_o     = res_o_q;
  assign bus.res_flag  = res_flag_q;
  assign op_count      = count_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 8-bit ALU on the alu_* bus.
// Define ALU_SEQ_ACC_EN to also exercise the accumulate path.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] op_count;
  int          total = 0;
  int          bad   = 0;

  alu_seq_if #(.WIDTH(8), .FLAGW(8)) bus ();

  alu_seq #(.WIDTH(8), .FLAGW(8), .CNTW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // ALU: flag[0]=carry, flag[1]=zero, flag[2]=negative.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (bus.alu_sel)
      ALU_SEL_ADD: alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_c};
      ALU_SEL_SUB: alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {8'd0, bus.alu_c};
      ALU_SEL_AND: alu_sum = {1'b0, bus.alu_a & bus.alu_b};
      default:     alu_sum = {1'b0, bus.alu_a | bus.alu_b};
    endcase
  end
  assign bus.alu_o    = alu_sum[7:0];
  assign bus.alu_flag = {5'd0, alu_sum[7], (alu_sum[7:0] == 8'd0), alu_sum[8]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                      input logic cin, input logic chain);
    check("send_ready", bus.cmd_ready, 1);
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_sel   = sel;
    bus.cmd_cin   = cin;
    bus.cmd_chain = chain;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  logic [7:0] b2b_a   [4] = '{8'h03, 8'hF0, 8'h81, 8'h7F};
  logic [7:0] b2b_b   [4] = '{8'h04, 8'h3C, 8'h02, 8'h01};
  logic [1:0] b2b_sel [4] = '{ALU_SEL_ADD, ALU_SEL_AND, ALU_SEL_OR, ALU_SEL_ADD};
  logic [7:0] b2b_res [4] = '{8'h07, 8'h30, 8'h83, 8'h80};
  logic [7:0] b2b_flg [4] = '{8'h00, 8'h00, 8'h04, 8'h04};

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_sel   = '0;
    bus.cmd_cin   = 1'b0;
    bus.cmd_chain = 1'b0;
    bus.res_ready = 1'b0;
`ifdef ALU_SEQ_ACC_EN
    bus.cmd_acc   = 1'b0;
`endif
    tick();
    tick();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_c", bus.alu_c, 0);
    check("rst_res_o", bus.res_o, 0);
    check("rst_op_count", op_count, 0);
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", bus.cmd_ready, 1);

    // Single op: 01+01 -> 02, two cycles after accept
    bus.res_ready = 1'b1;
    send(8'h01, 8'h01, ALU_SEL_ADD, 1'b0, 1'b0);
    check("t1_ready_exec", bus.cmd_ready, 0);
    check("t1_valid_exec", bus.res_valid, 0);
    check("t1_alu_a", bus.alu_a, 8'h01);
    tick();
    check("t1_res_valid", bus.res_valid, 1);
    check("t1_res_o", bus.res_o, 8'h02);
    check("t1_ready_hold", bus.cmd_ready, 1);
    tick();
    check("t1_op_count", op_count, 1);
    check("t1_valid_drop", bus.res_valid, 0);

    // Carry chain: FF+FF -> FE carry, then 00+00+carry -> 01
    send(8'hFF, 8'hFF, ALU_SEL_ADD, 1'b0, 1'b0);
    tick();
    check("t2_res_o_lo", bus.res_o, 8'hFE);
    check("t2_flag_lo", bus.res_flag, 8'h05);
    tick();
    send(8'h00, 8'h00, ALU_SEL_ADD, 1'b0, 1'b1);
    check("t2_alu_c", bus.alu_c, 1);
    tick();
    check("t2_res_o_hi", bus.res_o, 8'h01);
    check("t2_flag_hi", bus.res_flag, 8'h00);
    tick();
    check("t2_op_count", op_count, 3);

    // Backpressure: 10-20 (sub, cin=1) -> F0, held for 5 cycles
    bus.res_ready = 1'b0;
    send(8'h10, 8'h20, ALU_SEL_SUB, 1'b1, 1'b0);
    tick();
    check("t3_res_valid", bus.res_valid, 1);
    check("t3_res_o", bus.res_o, 8'hF0);
    bus.cmd_a     = 8'h99;
    bus.cmd_b     = 8'h66;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", bus.res_valid, 1);
      check("t3_hold_res_o", bus.res_o, 8'hF0);
      check("t3_hold_flag", bus.res_flag, 8'h04);
      check("t3_hold_ready", bus.cmd_ready, 0);
      check("t3_hold_alu_a", bus.alu_a, 8'h10);
    end
    check("t3_count_stall", op_count, 3);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    check("t3_op_count", op_count, 4);
    check("t3_valid_drop", bus.res_valid, 0);

    // Back-to-back: four commands, results on alternate cycles in order
    bus.cmd_a     = b2b_a[0];
    bus.cmd_b     = b2b_b[0];
    bus.cmd_sel   = b2b_sel[0];
    bus.cmd_cin   = 1'b0;
    bus.cmd_chain = 1'b0;
    bus.cmd_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.cmd_a   = b2b_a[i+1];
        bus.cmd_b   = b2b_b[i+1];
        bus.cmd_sel = b2b_sel[i+1];
      end else begin
        bus.cmd_valid = 1'b0;
      end
      check("t4_exec_valid", bus.res_valid, 0);
      tick();
      check("t4_res_valid", bus.res_valid, 1);
      check("t4_res_o", bus.res_o, b2b_res[i]);
      check("t4_res_flag", bus.res_flag, b2b_flg[i]);
      tick();
    end
    check("t4_op_count", op_count, 8);
    check("t4_idle_ready", bus.cmd_ready, 1);

    // Async reset while in EXEC
    send(8'h11, 8'h22, ALU_SEL_ADD, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_res_valid", bus.res_valid, 0);
    check("t5_cmd_ready", bus.cmd_ready, 0);
    check("t5_alu_a", bus.alu_a, 0);
    check("t5_alu_sel", bus.alu_sel, 0);
    check("t5_res_o", bus.res_o, 0);
    check("t5_res_flag", bus.res_flag, 0);
    check("t5_op_count", op_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_no_stale", bus.res_valid, 0);
    check("t5_cnt_stays", op_count, 0);
    send(8'h05, 8'h06, ALU_SEL_ADD, 1'b0, 1'b0);
    tick();
    check("t5_post_res_o", bus.res_o, 8'h0B);
    tick();
    check("t5_post_count", op_count, 1);

`ifdef ALU_SEQ_ACC_EN
    // Accumulate: load 55, then acc + AA -> FF
    send(8'h55, 8'h00, ALU_SEL_ADD, 1'b0, 1'b0);
    tick();
    check("t6_load", bus.res_o, 8'h55);
    tick();
    bus.cmd_acc = 1'b1;
    send(8'h12, 8'hAA, ALU_SEL_ADD, 1'b0, 1'b0);
    bus.cmd_acc = 1'b0;
    check("t6_alu_a", bus.alu_a, 8'h55);
    tick();
    check("t6_res_o", bus.res_o, 8'hFF);
    tick();
    check("t6_op_count", op_count, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
